// File: rtl/dldo_ctrl_pkg.sv
// Shared types and sizing helpers for the digital LDO loop controller.
// State encodings are visible on the debug port, so they are fixed here.
package dldo_ctrl_pkg;

  localparam int STATE_W = 32'sd3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_SAR_WAIT = 3'd2,
    ST_SETTLE   = 3'd3,
    ST_TRACK    = 3'd4,
    ST_LOCKED   = 3'd5
  } ctrl_state_e;

  // Signed error needs one extra bit so the full unsigned range never wraps.
  function automatic int err_width(input int width);
    return width + 32'sd1;
  endfunction

  function automatic int cnt_width(input int limit);
    return $clog2(limit) + 32'sd1;
  endfunction

endpackage

// File: rtl/dldo_err_classify.sv
// Combinational error classifier: magnitude, sign and band flags of vin - vref.
// sign=1 means vin < vref (output below reference, more current needed).
module dldo_err_classify
  import dldo_ctrl_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int LOCK_BAND   = 1,
  parameter int RETRIG_BAND = 7
) (
  input  logic [WIDTH-1:0] vin,
  input  logic [WIDTH-1:0] vref,
  output logic [WIDTH-1:0] abs_err,
  output logic             sign,
  output logic             in_band,
  output logic             retrig
);

  localparam int              EW          = err_width(WIDTH);
  localparam logic [WIDTH-1:0] LOCK_BAND_W = WIDTH'(LOCK_BAND);
  localparam logic [WIDTH-1:0] RETRIG_W    = WIDTH'(RETRIG_BAND);

  logic [EW-1:0] err_s;

  // Negating the low WIDTH bits is exact because |err| never exceeds 2^WIDTH-1.
  always_comb begin
    err_s = {1'b0, vin} - {1'b0, vref};
    sign  = err_s[EW-1];
    if (sign) begin
      abs_err = ~err_s[WIDTH-1:0] + WIDTH'(1);
    end else begin
      abs_err = err_s[WIDTH-1:0];
    end
    in_band = (abs_err <= LOCK_BAND_W);
    retrig  = (abs_err >= RETRIG_W);
  end

endmodule

// File: rtl/dldo_loop_ctrl.sv
// Digital LDO loop sequencer: SAR coarse search, counter fine trim, lock detect
// and SAR watchdog. Every output is taken straight from a flop.
module dldo_loop_ctrl
  import dldo_ctrl_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 2,
  parameter int LOCK_BAND     = 1,
  parameter int RETRIG_BAND   = 7,
  parameter int LOCK_COUNT    = 4,
  parameter int SAR_TIMEOUT   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] vin,
  input  logic [WIDTH-1:0] vref,
  input  logic             sar_done,
  output logic             sar_start,
  output logic             sar_abort,
  output logic             cnt_up,
  output logic             cnt_dn,
  output logic             locked,
  output logic             fault,
  output logic [2:0]       state
);

  localparam int SW = cnt_width(SETTLE_CYCLES);
  localparam int WW = cnt_width(SAR_TIMEOUT);
  localparam int IW = cnt_width(LOCK_COUNT);

  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [WW-1:0] WD_LAST     = WW'(SAR_TIMEOUT - 1);
  localparam logic [IW-1:0] IB_LAST     = IW'(LOCK_COUNT - 1);

  ctrl_state_e   state_r, state_s;
  logic [SW-1:0] settle_r, settle_s;
  logic [WW-1:0] wd_r, wd_s;
  logic [IW-1:0] ib_r, ib_s;
  logic          en_prev_r;
  logic          fault_r, fault_s;
  logic          sar_start_r, sar_abort_r, cnt_up_r, cnt_dn_r, locked_r;
  logic          start_s, abort_s, up_s, dn_s, locked_s;

  logic [WIDTH-1:0] abs_err;
  logic             sign, in_band, retrig;

  dldo_err_classify #(
    .WIDTH       (WIDTH),
    .LOCK_BAND   (LOCK_BAND),
    .RETRIG_BAND (RETRIG_BAND)
  ) u_classify (
    .vin     (vin),
    .vref    (vref),
    .abs_err (abs_err),
    .sign    (sign),
    .in_band (in_band),
    .retrig  (retrig)
  );

  // Next-state, counter and pulse decode; en=0 overrides every state.
  always_comb begin
    state_s  = state_r;
    settle_s = settle_r;
    wd_s     = wd_r;
    ib_s     = ib_r;
    abort_s  = 1'b0;
    up_s     = 1'b0;
    dn_s     = 1'b0;
    if (en_prev_r && !en) begin
      fault_s = 1'b0;
    end else begin
      fault_s = fault_r;
    end

    if (!en) begin
      state_s  = ST_IDLE;
      settle_s = '0;
      wd_s     = '0;
      ib_s     = '0;
      abort_s  = (state_r == ST_SAR_WAIT);
    end else begin
      case (state_r)
        ST_IDLE: begin
          settle_s = '0;
          wd_s     = '0;
          ib_s     = '0;
          if (fault_r) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_START;
          end
        end
        ST_START: begin
          wd_s    = '0;
          state_s = ST_SAR_WAIT;
        end
        ST_SAR_WAIT: begin
          // A completion on the expiry cycle still counts as success.
          if (sar_done) begin
            state_s  = ST_SETTLE;
            settle_s = '0;
            wd_s     = '0;
          end else if (wd_r == WD_LAST) begin
            state_s = ST_IDLE;
            wd_s    = '0;
            abort_s = 1'b1;
            fault_s = 1'b1;
          end else begin
            wd_s = wd_r + WW'(1);
          end
        end
        ST_SETTLE: begin
          if (settle_r == SETTLE_LAST) begin
            state_s  = ST_TRACK;
            settle_s = '0;
          end else begin
            settle_s = settle_r + SW'(1);
          end
        end
        ST_TRACK: begin
          if (retrig) begin
            state_s = ST_START;
            ib_s    = '0;
          end else if (in_band) begin
            ib_s = ib_r + IW'(1);
            if (ib_r >= IB_LAST) begin
              state_s = ST_LOCKED;
            end else begin
              state_s = ST_TRACK;
            end
          end else begin
            ib_s     = '0;
            settle_s = '0;
            state_s  = ST_SETTLE;
            up_s     = sign;
            dn_s     = !sign && (abs_err != '0);
          end
        end
        ST_LOCKED: begin
          if (retrig) begin
            state_s = ST_START;
            ib_s    = '0;
          end else if (!in_band) begin
            state_s = ST_TRACK;
            ib_s    = '0;
          end else begin
            state_s = ST_LOCKED;
          end
        end
        default: begin
          state_s  = ST_IDLE;
          settle_s = '0;
          wd_s     = '0;
          ib_s     = '0;
        end
      endcase
    end

    start_s  = (state_s == ST_START);
    locked_s = (state_s == ST_LOCKED);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      settle_r    <= '0;
      wd_r        <= '0;
      ib_r        <= '0;
      en_prev_r   <= 1'b0;
      fault_r     <= 1'b0;
      sar_start_r <= 1'b0;
      sar_abort_r <= 1'b0;
      cnt_up_r    <= 1'b0;
      cnt_dn_r    <= 1'b0;
      locked_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      settle_r    <= settle_s;
      wd_r        <= wd_s;
      ib_r        <= ib_s;
      en_prev_r   <= en;
      fault_r     <= fault_s;
      sar_start_r <= start_s;
      sar_abort_r <= abort_s;
      cnt_up_r    <= up_s;
      cnt_dn_r    <= dn_s;
      locked_r    <= locked_s;
    end
  end

  assign sar_start = sar_start_r;
  assign sar_abort = sar_abort_r;
  assign cnt_up    = cnt_up_r;
  assign cnt_dn    = cnt_dn_r;
  assign locked    = locked_r;
  assign fault     = fault_r;
  assign state     = state_r;

endmodule

// File: tb/tb_dldo_loop_ctrl.sv
// Bench for dldo_loop_ctrl: directed loop scenarios plus random stimulus,
// checked every cycle against a deadline-based behavioural model.
module tb_dldo_loop_ctrl;
  import dldo_ctrl_pkg::*;

  localparam int WIDTH  = 8;
  localparam int SETTLE = 2;
  localparam int LB     = 1;
  localparam int RB     = 7;
  localparam int LC     = 4;
  localparam int TO     = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic [WIDTH-1:0] vin;
  logic [WIDTH-1:0] vref;
  logic             sar_done;
  logic             sar_start, sar_abort, cnt_up, cnt_dn, locked, fault;
  logic [2:0]       state;

  dldo_loop_ctrl #(
    .WIDTH(WIDTH), .SETTLE_CYCLES(SETTLE), .LOCK_BAND(LB),
    .RETRIG_BAND(RB), .LOCK_COUNT(LC), .SAR_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .vin(vin), .vref(vref),
    .sar_done(sar_done), .sar_start(sar_start), .sar_abort(sar_abort),
    .cnt_up(cnt_up), .cnt_dn(cnt_dn), .locked(locked), .fault(fault),
    .state(state)
  );

  always #5 clk = ~clk;

  int    n_total = 0;
  int    n_bad   = 0;
  int    n_start, n_up, n_dn;
  string cur_tag = "init";

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model: timing is tracked as absolute cycle deadlines.
  ctrl_state_e m_state;
  bit m_start, m_abort, m_up, m_dn, m_locked, m_fault, m_en_prev;
  int m_cyc, m_settle_end, m_wd_end, m_run;

  task automatic model_reset();
    m_state = ST_IDLE;
    m_start = 0; m_abort = 0; m_up = 0; m_dn = 0; m_locked = 0; m_fault = 0;
    m_en_prev = 0; m_run = 0; m_settle_end = 0; m_wd_end = 0;
  endtask

  task automatic model_step();
    int err, mag;
    m_cyc++;
    err = int'(vin) - int'(vref);
    mag = (err < 0) ? -err : err;
    m_abort = 0; m_up = 0; m_dn = 0;
    if (m_en_prev && !en) m_fault = 0;
    if (!en) begin
      m_abort = (m_state == ST_SAR_WAIT);
      m_state = ST_IDLE;
      m_run   = 0;
    end else begin
      case (m_state)
        ST_IDLE: begin
          m_run = 0;
          if (!m_fault) m_state = ST_START;
        end
        ST_START: begin
          m_state  = ST_SAR_WAIT;
          m_wd_end = m_cyc + TO;
        end
        ST_SAR_WAIT: begin
          if (sar_done) begin
            m_state      = ST_SETTLE;
            m_settle_end = m_cyc + SETTLE;
          end else if (m_cyc == m_wd_end) begin
            m_fault = 1; m_abort = 1; m_state = ST_IDLE;
          end
        end
        ST_SETTLE: if (m_cyc == m_settle_end) m_state = ST_TRACK;
        ST_TRACK: begin
          if (mag >= RB) begin
            m_state = ST_START; m_run = 0;
          end else if (mag <= LB) begin
            m_run++;
            if (m_run == LC) m_state = ST_LOCKED;
          end else begin
            if (err < 0) m_up = 1; else m_dn = 1;
            m_run = 0;
            m_state = ST_SETTLE;
            m_settle_end = m_cyc + SETTLE;
          end
        end
        ST_LOCKED: begin
          if (mag >= RB) begin
            m_state = ST_START; m_run = 0;
          end else if (mag > LB) begin
            m_state = ST_TRACK; m_run = 0;
          end
        end
        default: m_state = ST_IDLE;
      endcase
    end
    m_start   = (m_state == ST_START);
    m_locked  = (m_state == ST_LOCKED);
    m_en_prev = en;
  endtask

  task automatic check_outputs();
    check_eq({cur_tag, "_state"},  32'(state),     32'(m_state));
    check_eq({cur_tag, "_start"},  32'(sar_start), 32'(m_start));
    check_eq({cur_tag, "_abort"},  32'(sar_abort), 32'(m_abort));
    check_eq({cur_tag, "_up"},     32'(cnt_up),    32'(m_up));
    check_eq({cur_tag, "_dn"},     32'(cnt_dn),    32'(m_dn));
    check_eq({cur_tag, "_locked"}, 32'(locked),    32'(m_locked));
    check_eq({cur_tag, "_fault"},  32'(fault),     32'(m_fault));
  endtask

  task automatic tick(input logic e, input logic [7:0] vi, input logic [7:0] vr, input logic d);
    @(negedge clk);
    en = e; vin = vi; vref = vr; sar_done = d;
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
    if (sar_start) n_start++;
    if (cnt_up) n_up++;
    if (cnt_dn) n_dn++;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_state"}, 32'(state), 32'd0);
    check_eq({tag, "_outs"}, 32'({sar_start, sar_abort, cnt_up, cnt_dn, locked, fault}), 32'd0);
  endtask

  initial begin
    int cnt_sw, starts_before, t, p_done;
    logic [7:0] rv, rr;
    logic e, d;

    rst_n = 1'b0; en = 1'b0; vin = 8'd0; vref = 8'd0; sar_done = 1'b0;
    m_cyc = 0; n_start = 0; n_up = 0; n_dn = 0;
    model_reset();
    #22;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Coarse search then lock with zero error.
    cur_tag = "lock";
    tick(1'b1, 8'd100, 8'd100, 1'b0);
    check_eq("lock_start_pulse", 32'(sar_start), 32'd1);
    tick(1'b1, 8'd100, 8'd100, 1'b0);
    tick(1'b1, 8'd100, 8'd100, 1'b0);
    tick(1'b1, 8'd100, 8'd100, 1'b1);
    check_eq("lock_settle", 32'(state), 32'(ST_SETTLE));
    tick(1'b1, 8'd100, 8'd100, 1'b0);
    tick(1'b1, 8'd100, 8'd100, 1'b0);
    check_eq("lock_track", 32'(state), 32'(ST_TRACK));
    repeat (3) tick(1'b1, 8'd100, 8'd100, 1'b0);
    check_eq("lock_early", 32'(locked), 32'd0);
    tick(1'b1, 8'd100, 8'd100, 1'b0);
    check_eq("lock_locked", 32'(locked), 32'd1);
    check_eq("lock_nstart", 32'(n_start), 32'd1);
    check_eq("lock_ncnt", 32'(n_up + n_dn), 32'd0);

    // Fine trim steps toward the reference.
    cur_tag = "trim"; n_up = 0; n_dn = 0;
    tick(1'b1, 8'd96, 8'd100, 1'b0);
    check_eq("trim_unlock", 32'(state), 32'(ST_TRACK));
    tick(1'b1, 8'd96, 8'd100, 1'b0);
    check_eq("trim_up1", 32'(cnt_up), 32'd1);
    tick(1'b1, 8'd96, 8'd100, 1'b0);
    tick(1'b1, 8'd96, 8'd100, 1'b0);
    check_eq("trim_retrack", 32'(state), 32'(ST_TRACK));
    tick(1'b1, 8'd97, 8'd100, 1'b0);
    check_eq("trim_up2", 32'(cnt_up), 32'd1);
    tick(1'b1, 8'd97, 8'd100, 1'b0);
    tick(1'b1, 8'd97, 8'd100, 1'b0);
    repeat (4) tick(1'b1, 8'd99, 8'd100, 1'b0);
    check_eq("trim_locked", 32'(locked), 32'd1);
    check_eq("trim_nup", 32'(n_up), 32'd2);
    check_eq("trim_ndn", 32'(n_dn), 32'd0);

    // Large step in lock forces a new search.
    cur_tag = "retrig";
    tick(1'b1, 8'd60, 8'd100, 1'b0);
    check_eq("retrig_start", 32'(state), 32'(ST_START));
    check_eq("retrig_unlock", 32'(locked), 32'd0);
    tick(1'b1, 8'd60, 8'd100, 1'b0);
    check_eq("retrig_wait", 32'(state), 32'(ST_SAR_WAIT));

    // SAR never answers: watchdog, sticky fault, restart via en toggle.
    cur_tag = "tmo";
    cnt_sw = 1;
    for (int i = 0; i < 40; i++) begin
      tick(1'b1, 8'd60, 8'd100, 1'b0);
      if (state == ST_SAR_WAIT) cnt_sw++;
      else break;
    end
    check_eq("tmo_cycles", 32'(cnt_sw), 32'(TO));
    check_eq("tmo_fault", 32'(fault), 32'd1);
    check_eq("tmo_abort", 32'(sar_abort), 32'd1);
    check_eq("tmo_idle", 32'(state), 32'(ST_IDLE));
    starts_before = n_start;
    repeat (8) tick(1'b1, 8'd60, 8'd100, 1'b0);
    check_eq("tmo_hold_nstart", 32'(n_start - starts_before), 32'd0);
    tick(1'b0, 8'd60, 8'd100, 1'b0);
    check_eq("tmo_fault_clr", 32'(fault), 32'd0);
    tick(1'b1, 8'd60, 8'd100, 1'b0);
    check_eq("tmo_restart", 32'(state), 32'(ST_START));

    // en dropped mid-search, then done racing the watchdog expiry.
    cur_tag = "drop";
    repeat (6) tick(1'b1, 8'd60, 8'd100, 1'b0);
    tick(1'b0, 8'd60, 8'd100, 1'b1);
    check_eq("drop_abort", 32'(sar_abort), 32'd1);
    check_eq("drop_idle", 32'(state), 32'(ST_IDLE));
    tick(1'b1, 8'd0, 8'd0, 1'b0);
    tick(1'b1, 8'd0, 8'd0, 1'b0);
    repeat (TO - 1) tick(1'b1, 8'd0, 8'd0, 1'b0);
    tick(1'b1, 8'd0, 8'd0, 1'b1);
    check_eq("race_settle", 32'(state), 32'(ST_SETTLE));
    check_eq("race_nofault", 32'(fault), 32'd0);

    // Full-scale error in both directions.
    cur_tag = "extreme";
    tick(1'b1, 8'd0, 8'd0, 1'b0);
    tick(1'b1, 8'd0, 8'd0, 1'b0);
    check_eq("ext_track1", 32'(state), 32'(ST_TRACK));
    tick(1'b1, 8'd255, 8'd0, 1'b0);
    check_eq("ext_abs_pos", 32'(dut.u_classify.abs_err), 32'd255);
    check_eq("ext_retrig_pos", 32'(state), 32'(ST_START));
    tick(1'b1, 8'd0, 8'd0, 1'b0);
    tick(1'b1, 8'd0, 8'd0, 1'b1);
    tick(1'b1, 8'd0, 8'd0, 1'b0);
    tick(1'b1, 8'd0, 8'd0, 1'b0);
    check_eq("ext_track2", 32'(state), 32'(ST_TRACK));
    tick(1'b1, 8'd0, 8'd255, 1'b0);
    check_eq("ext_abs_neg", 32'(dut.u_classify.abs_err), 32'd255);
    check_eq("ext_retrig_neg", 32'(state), 32'(ST_START));

    // Random stimulus against the model.
    cur_tag = "rand";
    rr = 8'd128; rv = 8'd128; p_done = 30;
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) p_done = ($urandom_range(0, 2) == 0) ? 0 : 30;
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0, 1: t = int'(rr) + int'($urandom_range(0, 6)) - 3;
          2: t = ($urandom_range(0, 1) == 0) ? int'(rr) + int'($urandom_range(4, 12))
                                             : int'(rr) - int'($urandom_range(4, 12));
          default: begin
            t  = int'($urandom_range(0, 255));
            rr = 8'($urandom_range(0, 255));
          end
        endcase
        if (t < 0) t = 0;
        if (t > 255) t = 255;
        rv = t[7:0];
      end
      e = ($urandom_range(0, 199) != 0);
      d = ($urandom_range(0, 99) < p_done);
      tick(e, rv, rr, d);
    end

    // Asynchronous reset between clock edges.
    #2;
    en = 1'b0; sar_done = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cur_tag = "post_rst";
    tick(1'b1, 8'd50, 8'd50, 1'b0);
    check_eq("post_rst_start", 32'(sar_start), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/dldo_loop_ctrl.md
# dldo_loop_ctrl

Sequencing controller for the digital LDO regulation loop. It decides when the SAR search engine runs, when the fine up/down counter trims the PMOS codeword, and when the loop is declared locked. It sits between the digitized vin/vref comparator path and the SAR/counter datapath that drives the PMOS array. It owns loop state, settle timing, lock detection and the SAR watchdog.

## Interface
Parameters:
- WIDTH, 8, width of vin/vref codes
- SETTLE_CYCLES, 2, wait cycles after any codeword change before the error is evaluated again (≥1)
- LOCK_BAND, 1, |err| ≤ LOCK_BAND counts as in-band
- RETRIG_BAND, 7, |err| ≥ RETRIG_BAND forces a new SAR search
- LOCK_COUNT, 4, consecutive in-band evaluations required to assert locked (≥1)
- SAR_TIMEOUT, 32, max cycles waiting for sar_done

Ports:
- clk, in, 1, single clock, all logic on the rising edge
- rst_n, in, 1, asynchronous active-low reset
- en, in, 1, loop enable, level
- vin, in, WIDTH, digitized output voltage, unsigned
- vref, in, WIDTH, digitized reference, unsigned
- sar_done, in, 1, SAR engine finished (one-cycle pulse or level)
- sar_start, out, 1, one-cycle pulse that launches a SAR search
- sar_abort, out, 1, one-cycle pulse that cancels an in-flight search
- cnt_up, out, 1, one-cycle pulse that increments the codeword (more current)
- cnt_dn, out, 1, one-cycle pulse that decrements the codeword
- locked, out, 1, loop in lock
- fault, out, 1, sticky SAR timeout flag
- state, out, 3, current state encoding (debug)

## Operation
- Error is err = vin − vref, computed sign-extended in WIDTH+1 bits with no wrap. abs_err is WIDTH bits. Max magnitude 2^WIDTH−1 is representable.
- States, with their encoding:
  - IDLE (0): all pulses low, locked=0. The controller moves to START when en=1.
  - START (1): sar_start=1 for this cycle only. It always moves to SAR_WAIT.
  - SAR_WAIT (2): the watchdog counts cycles.
    - sar_done=1 → SETTLE.
    - Watchdog reaches SAR_TIMEOUT → fault=1, sar_abort pulse, then IDLE.
  - SETTLE (3): counts SETTLE_CYCLES, then moves to TRACK. The in-band counter is not cleared here.
  - TRACK (4): evaluates err once per visit.
    - abs_err ≥ RETRIG_BAND → START, in-band counter cleared.
    - abs_err ≤ LOCK_BAND → in-band counter +1. Reaching LOCK_COUNT → LOCKED; otherwise stay in TRACK and evaluate again next cycle.
    - Otherwise: cnt_up if vin < vref, cnt_dn if vin > vref. In-band counter cleared, then SETTLE.
  - LOCKED (5): locked=1.
    - abs_err ≥ RETRIG_BAND → START.
    - abs_err > LOCK_BAND → TRACK.
    - Leaving LOCKED clears locked and the in-band counter.
- en=0 in any state → IDLE on the next edge.
  - If leaving SAR_WAIT, sar_abort pulses on that edge.
  - The settle, watchdog and in-band counters clear.
- fault is sticky. It clears only on rst_n=0 or on an en 1→0 transition. START is not entered while fault=1, even with en=1.
- cnt_up and cnt_dn are never high together. sar_start is never high together with cnt_up or cnt_dn.

## Timing
- All outputs are registered. Reset values: state=IDLE, sar_start=0, sar_abort=0, cnt_up=0, cnt_dn=0, locked=0, fault=0.
- en sampled 1 at edge N → sar_start high during cycle N..N+1.
- sar_done sampled at edge M → SETTLE starts at M. TRACK is reached at M+SETTLE_CYCLES.
- Trim step: cnt_* pulse is driven for one cycle, followed by SETTLE_CYCLES cycles of settling, then the next evaluation.
- Lock latency from the first in-band sample is LOCK_COUNT−1 further cycles. locked rises on the edge that enters LOCKED.
- sar_done arriving in any state other than SAR_WAIT is ignored.
- sar_done and en=0 on the same edge: en=0 wins (IDLE plus sar_abort).
- sar_done and the watchdog expiring on the same edge: sar_done wins, no fault.
- rst_n assertion is asynchronous and clears all state immediately. Deassertion is synchronized externally.

## Structure
- Package dldo_ctrl_pkg holds the state enum with the encodings above and the err width rule (WIDTH+1).
- Sub-module dldo_err_classify (combinational) takes vin and vref and produces abs_err, sign, in_band and retrig.
- The top level holds the FSM, the settle counter, the watchdog counter and the in-band counter. Counter widths are sized with $clog2 of the respective parameter plus 1.

## Test plan
- Reset, then en=1, vin=100, vref=100, sar_done pulsed 3 cycles after sar_start → one sar_start, TRACK after 2 settle cycles, locked=1 after 4 in-band cycles, no cnt pulses.
- In TRACK, vin=96, vref=100 (err=−4) → cnt_up pulse, 2 settle cycles, re-evaluate. Set vin=97 → second cnt_up. Set vin=99 → lock after 4 cycles.
- In LOCKED, step vin from 100 to 60 → locked falls, sar_start pulses on the next edge, state=START then SAR_WAIT.
- sar_done never arrives → fault=1 and sar_abort pulse at cycle 32 of SAR_WAIT, then IDLE. en held 1 gives no restart. en toggled 0→1 clears fault and restarts.
- en dropped during SAR_WAIT → sar_abort pulse, IDLE next cycle, all counters cleared.
- vin=255, vref=0 and vin=0, vref=255 → abs_err=255 with no wrap, and a retrigger occurs in both cases.
